mux_arbiter: RTL and testbench



---
 rtl/mux_arb_pkg.sv | 18 +
 rtl/mux_arb_beat_cnt.sv | 34 +++
 rtl/mux_arbiter.sv | 116 +++++++++++
 tb/tb_mux_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the two-requester burst arbiter.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  localparam logic SEL_DIN0 = 1'b0;
  localparam logic SEL_DIN1 = 1'b1;

  // Room for 0..MAX_BURST so the beat counter can never wrap.
  function automatic int cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/mux_arb_beat_cnt.sv
// Per-grant beat counter; o_tc flags the beat that must close the burst.
module mux_arb_beat_cnt
  import mux_arb_pkg::*;
#(
  parameter int MAX_BURST = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_tc
);

  localparam int CW = cnt_width(MAX_BURST);
  localparam logic [CW-1:0] TC_VAL = CW'(MAX_BURST - 1);

  logic [CW-1:0] r_cnt;
  logic          w_tc;

  assign w_tc = (r_cnt == TC_VAL);
  assign o_tc = w_tc;

  // Clear wins over increment; the hold at terminal count keeps the value in range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_tc) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin burst arbiter driving the shared 2:1 data mux and its select.
//   state  | meaning
//   IDLE   | no grant, readies low, arbitrating on valids and ptr
//   GRANT0 | din_0 passed through until burst end
//   GRANT1 | din_1 passed through until burst end
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din_0_data,
  input  logic             din_0_valid,
  input  logic             din_0_last,
  output logic             din_0_ready,
  input  logic [WIDTH-1:0] din_1_data,
  input  logic             din_1_valid,
  input  logic             din_1_last,
  output logic             din_1_ready,
  output logic [WIDTH-1:0] mux_out_data,
  output logic             mux_out_valid,
  output logic             mux_out_last,
  input  logic             mux_out_ready,
  output logic             sel,
  output logic             busy
);

  arb_state_t r_state, w_state_nxt;
  logic       r_sel, w_sel_nxt;
  logic       r_ptr, w_ptr_nxt;
  logic       w_xfer, w_end, w_tc;

  mux_arb_beat_cnt #(.MAX_BURST(MAX_BURST)) u_beat_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_xfer),
    .i_clr (w_end),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sel   <= SEL_DIN0;
      r_ptr   <= SEL_DIN0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_sel_nxt     = r_sel;
    w_ptr_nxt     = r_ptr;
    w_xfer        = 1'b0;
    w_end         = 1'b0;
    din_0_ready   = 1'b0;
    din_1_ready   = 1'b0;
    mux_out_valid = 1'b0;
    mux_out_last  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (din_0_valid && (!din_1_valid || r_ptr == SEL_DIN0)) begin
          w_state_nxt = GRANT0;
          w_sel_nxt   = SEL_DIN0;
        end else if (din_1_valid) begin
          w_state_nxt = GRANT1;
          w_sel_nxt   = SEL_DIN1;
        end
      end
      GRANT0: begin
        mux_out_valid = din_0_valid;
        din_0_ready   = mux_out_ready;
        mux_out_last  = din_0_last | w_tc;
        w_xfer        = din_0_valid & mux_out_ready;
        w_end         = w_xfer & (din_0_last | w_tc);
        // Hand straight over when the other side is waiting, avoiding an IDLE bubble.
        if (w_end) begin
          w_ptr_nxt = SEL_DIN1;
          if (din_1_valid) begin
            w_state_nxt = GRANT1;
            w_sel_nxt   = SEL_DIN1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      GRANT1: begin
        mux_out_valid = din_1_valid;
        din_1_ready   = mux_out_ready;
        mux_out_last  = din_1_last | w_tc;
        w_xfer        = din_1_valid & mux_out_ready;
        w_end         = w_xfer & (din_1_last | w_tc);
        if (w_end) begin
          w_ptr_nxt = SEL_DIN0;
          if (din_0_valid) begin
            w_state_nxt = GRANT0;
            w_sel_nxt   = SEL_DIN0;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign mux_out_data = (r_sel == SEL_DIN1) ? din_1_data : din_0_data;
  assign sel          = r_sel;
  assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter with MAX_BURST = 16, 4 and 1 instances on shared inputs.
module tb_mux_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] din_0_data, din_1_data;
  logic       din_0_valid, din_0_last, din_1_valid, din_1_last, mux_out_ready;
  logic [2:0] o_r0, o_r1, o_v, o_l, o_sel, o_busy;
  logic [7:0] o_d [3];

  mux_arbiter #(.WIDTH(8), .MAX_BURST(16)) u_dut16 (
    .clk(clk), .rst(rst),
    .din_0_data(din_0_data), .din_0_valid(din_0_valid), .din_0_last(din_0_last), .din_0_ready(o_r0[0]),
    .din_1_data(din_1_data), .din_1_valid(din_1_valid), .din_1_last(din_1_last), .din_1_ready(o_r1[0]),
    .mux_out_data(o_d[0]), .mux_out_valid(o_v[0]), .mux_out_last(o_l[0]), .mux_out_ready(mux_out_ready),
    .sel(o_sel[0]), .busy(o_busy[0]));

  mux_arbiter #(.WIDTH(8), .MAX_BURST(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .din_0_data(din_0_data), .din_0_valid(din_0_valid), .din_0_last(din_0_last), .din_0_ready(o_r0[1]),
    .din_1_data(din_1_data), .din_1_valid(din_1_valid), .din_1_last(din_1_last), .din_1_ready(o_r1[1]),
    .mux_out_data(o_d[1]), .mux_out_valid(o_v[1]), .mux_out_last(o_l[1]), .mux_out_ready(mux_out_ready),
    .sel(o_sel[1]), .busy(o_busy[1]));

  mux_arbiter #(.WIDTH(8), .MAX_BURST(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .din_0_data(din_0_data), .din_0_valid(din_0_valid), .din_0_last(din_0_last), .din_0_ready(o_r0[2]),
    .din_1_data(din_1_data), .din_1_valid(din_1_valid), .din_1_last(din_1_last), .din_1_ready(o_r1[2]),
    .mux_out_data(o_d[2]), .mux_out_valid(o_v[2]), .mux_out_last(o_l[2]), .mux_out_ready(mux_out_ready),
    .sel(o_sel[2]), .busy(o_busy[2]));

  int errors = 0;
  int checks = 0;
  int cur = 0;
  int cyc = 0;

  logic [7:0] q0_d [$];
  logic [7:0] q1_d [$];
  logic       q0_l [$];
  logic       q1_l [$];
  logic       en0, en1;

  logic [7:0] cap_d [$];
  logic       cap_l [$];
  logic       cap_s [$];
  int         cap_c [$];

  logic       ob_r0, ob_r1, ob_v, ob_l, ob_sel, ob_busy;
  logic [7:0] ob_d;

  task automatic sample();
    ob_r0   = o_r0[cur];
    ob_r1   = o_r1[cur];
    ob_v    = o_v[cur];
    ob_l    = o_l[cur];
    ob_sel  = o_sel[cur];
    ob_busy = o_busy[cur];
    ob_d    = o_d[cur];
  endtask

  task automatic drive();
    din_0_valid = en0 && (q0_d.size() != 0);
    din_0_data  = (q0_d.size() != 0) ? q0_d[0] : 8'h00;
    din_0_last  = (q0_l.size() != 0) ? q0_l[0] : 1'b0;
    din_1_valid = en1 && (q1_d.size() != 0);
    din_1_data  = (q1_d.size() != 0) ? q1_d[0] : 8'h00;
    din_1_last  = (q1_l.size() != 0) ? q1_l[0] : 1'b0;
  endtask

  // One clock: drive sources, sample at negedge, log transfers and pop accepted beats.
  task automatic step();
    drive();
    @(negedge clk);
    sample();
    if (ob_v && mux_out_ready) begin
      cap_d.push_back(ob_d);
      cap_l.push_back(ob_l);
      cap_s.push_back(ob_sel);
      cap_c.push_back(cyc);
    end
    if (ob_r0 && din_0_valid) begin
      q0_d.delete(0);
      q0_l.delete(0);
    end
    if (ob_r1 && din_1_valid) begin
      q1_d.delete(0);
      q1_l.delete(0);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int inst);
    cur = inst;
    rst = 1'b1;
    en0 = 1'b0;
    en1 = 1'b0;
    q0_d.delete(); q0_l.delete(); q1_d.delete(); q1_l.delete();
    cap_d.delete(); cap_l.delete(); cap_s.delete(); cap_c.delete();
    mux_out_ready = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    do_reset(0);
    for (int i = 0; i < 5; i++) begin
      q1_d.push_back(8'h1A + 8'(i));
      q1_l.push_back(1'b0);
    end
    en1 = 1'b1;
    repeat (3) step();
    drive();
    din_0_data = 8'h5A;
    #2;
    sample();
    checks++; if (ob_busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %0b expected 1", ob_busy); end
    checks++; if (ob_sel !== 1'b1) begin errors++; $display("FAIL rst_pre_sel: got %0b expected 1", ob_sel); end
    rst = 1'b1;
    #1;
    sample();
    checks++; if (ob_r1 !== 1'b0) begin errors++; $display("FAIL rst_ready1: got %0b expected 0", ob_r1); end
    checks++; if (ob_r0 !== 1'b0) begin errors++; $display("FAIL rst_ready0: got %0b expected 0", ob_r0); end
    checks++; if (ob_v !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b expected 0", ob_v); end
    checks++; if (ob_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b expected 0", ob_busy); end
    checks++; if (ob_sel !== 1'b0) begin errors++; $display("FAIL rst_sel: got %0b expected 0", ob_sel); end
    checks++; if (ob_l !== 1'b0) begin errors++; $display("FAIL rst_last: got %0b expected 0", ob_l); end
    checks++; if (ob_d !== 8'h5A) begin errors++; $display("FAIL rst_data: got %0h expected 5a", ob_d); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    q0_d.push_back(8'h01);
    q0_l.push_back(1'b1);
    en0 = 1'b1;
    step();
    checks++; if (ob_busy !== 1'b0) begin errors++; $display("FAIL rst_idle_after: busy got %0b expected 0", ob_busy); end
    step();
    checks++; if (ob_sel !== 1'b0) begin errors++; $display("FAIL rst_ptr0: sel got %0b expected 0", ob_sel); end
    checks++; if (ob_r0 !== 1'b1) begin errors++; $display("FAIL rst_ptr0_ready: got %0b expected 1", ob_r0); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp_d [5] = '{8'h0A, 8'h0B, 8'h0C, 8'h1A, 8'h1B};
    logic       exp_l [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset(0);
    q0_d = '{8'h0A, 8'h0B, 8'h0C}; q0_l = '{1'b0, 1'b0, 1'b1};
    q1_d = '{8'h1A, 8'h1B};        q1_l = '{1'b0, 1'b1};
    en0 = 1'b1;
    en1 = 1'b1;
    step();
    checks++; if (ob_busy !== 1'b0) begin errors++; $display("FAIL sim_latency: busy got %0b expected 0", ob_busy); end
    repeat (6) step();
    checks++; if (ob_busy !== 1'b0) begin errors++; $display("FAIL sim_idle_end: busy got %0b expected 0", ob_busy); end
    checks++;
    if (cap_d.size() != 5) begin
      errors++; $display("FAIL sim_count: got %0d beats expected 5", cap_d.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (cap_d[i] !== exp_d[i]) begin errors++; $display("FAIL sim_data[%0d]: got %0h expected %0h", i, cap_d[i], exp_d[i]); end
        checks++; if (cap_l[i] !== exp_l[i]) begin errors++; $display("FAIL sim_last[%0d]: got %0b expected %0b", i, cap_l[i], exp_l[i]); end
      end
      checks++; if (cap_c[0] !== 1) begin errors++; $display("FAIL sim_first_cycle: got %0d expected 1", cap_c[0]); end
      checks++; if (cap_c[3] !== cap_c[2] + 1) begin errors++; $display("FAIL sim_no_bubble: got cycle %0d expected %0d", cap_c[3], cap_c[2] + 1); end
    end
  endtask

  task automatic test_forced_release();
    logic [7:0] exp_d [12] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h80, 8'h04, 8'h05, 8'h06, 8'h07, 8'h81, 8'h08, 8'h09};
    logic       exp_l [12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       exp_s [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset(1);
    for (int i = 0; i < 10; i++) begin
      q0_d.push_back(8'(i));
      q0_l.push_back(1'b0);
    end
    q1_d = '{8'h80, 8'h81}; q1_l = '{1'b1, 1'b1};
    en0 = 1'b1;
    en1 = 1'b1;
    repeat (16) step();
    checks++; if (ob_busy !== 1'b1) begin errors++; $display("FAIL frc_hold_busy: got %0b expected 1", ob_busy); end
    checks++; if (ob_sel !== 1'b0) begin errors++; $display("FAIL frc_hold_sel: got %0b expected 0", ob_sel); end
    checks++;
    if (cap_d.size() != 12) begin
      errors++; $display("FAIL frc_count: got %0d beats expected 12", cap_d.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        checks++; if (cap_d[i] !== exp_d[i]) begin errors++; $display("FAIL frc_data[%0d]: got %0h expected %0h", i, cap_d[i], exp_d[i]); end
        checks++; if (cap_l[i] !== exp_l[i]) begin errors++; $display("FAIL frc_last[%0d]: got %0b expected %0b", i, cap_l[i], exp_l[i]); end
        checks++; if (cap_s[i] !== exp_s[i]) begin errors++; $display("FAIL frc_sel[%0d]: got %0b expected %0b", i, cap_s[i], exp_s[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_d [5] = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h50};
    logic       seen43 = 1'b0;
    logic       pre;
    do_reset(0);
    q0_d = '{8'h40, 8'h41, 8'h42, 8'h43}; q0_l = '{1'b0, 1'b0, 1'b0, 1'b1};
    q1_d = '{8'h50};                      q1_l = '{1'b1};
    en1 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      mux_out_ready = (i % 2 == 0);
      en0 = !(i == 3 || i == 4 || i == 7);
      pre = seen43;
      step();
      if (!pre) begin
        checks++; if (ob_r1 !== 1'b0) begin errors++; $display("FAIL bp_ready1[%0d]: got %0b expected 0", i, ob_r1); end
        checks++; if (ob_sel !== 1'b0) begin errors++; $display("FAIL bp_sel[%0d]: got %0b expected 0", i, ob_sel); end
      end
      if (cap_d.size() != 0 && cap_d[$] == 8'h43) seen43 = 1'b1;
    end
    mux_out_ready = 1'b1;
    checks++;
    if (cap_d.size() != 5) begin
      errors++; $display("FAIL bp_count: got %0d beats expected 5", cap_d.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (cap_d[i] !== exp_d[i]) begin errors++; $display("FAIL bp_data[%0d]: got %0h expected %0h", i, cap_d[i], exp_d[i]); end
      end
    end
  endtask

  task automatic test_single();
    logic [7:0] exp_d [7] = '{8'h01, 8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h02, 8'h1F};
    do_reset(0);
    q0_d = '{8'h01}; q0_l = '{1'b1};
    en0 = 1'b1;
    repeat (2) step();
    q1_d = '{8'h1A, 8'h1B}; q1_l = '{1'b0, 1'b1};
    en1 = 1'b1;
    step();
    checks++; if (ob_busy !== 1'b0) begin errors++; $display("FAIL sgl_idle1: busy got %0b expected 0", ob_busy); end
    step();
    checks++; if (ob_busy !== 1'b1) begin errors++; $display("FAIL sgl_grant1_busy: got %0b expected 1", ob_busy); end
    checks++; if (ob_sel !== 1'b1) begin errors++; $display("FAIL sgl_grant1_sel: got %0b expected 1", ob_sel); end
    repeat (3) step();
    q1_d = '{8'h1C, 8'h1D}; q1_l = '{1'b0, 1'b1};
    step();
    checks++; if (ob_busy !== 1'b0) begin errors++; $display("FAIL sgl_idle2: busy got %0b expected 0", ob_busy); end
    step();
    checks++; if (ob_busy !== 1'b1) begin errors++; $display("FAIL sgl_grant2_busy: got %0b expected 1", ob_busy); end
    checks++; if (ob_sel !== 1'b1) begin errors++; $display("FAIL sgl_grant2_sel: got %0b expected 1", ob_sel); end
    step();
    q0_d = '{8'h02}; q0_l = '{1'b1};
    q1_d = '{8'h1F}; q1_l = '{1'b1};
    step();
    step();
    checks++; if (ob_sel !== 1'b0) begin errors++; $display("FAIL sgl_ptr_toggle: sel got %0b expected 0", ob_sel); end
    repeat (2) step();
    checks++;
    if (cap_d.size() != 7) begin
      errors++; $display("FAIL sgl_count: got %0d beats expected 7", cap_d.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        checks++; if (cap_d[i] !== exp_d[i]) begin errors++; $display("FAIL sgl_data[%0d]: got %0h expected %0h", i, cap_d[i], exp_d[i]); end
      end
    end
  endtask

  task automatic test_max_burst_one();
    logic [7:0] exp_d [6] = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2};
    logic       exp_s [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset(2);
    q0_d = '{8'hA0, 8'hA1, 8'hA2}; q0_l = '{1'b0, 1'b0, 1'b0};
    q1_d = '{8'hB0, 8'hB1, 8'hB2}; q1_l = '{1'b0, 1'b0, 1'b0};
    en0 = 1'b1;
    en1 = 1'b1;
    repeat (8) step();
    checks++;
    if (cap_d.size() != 6) begin
      errors++; $display("FAIL mb1_count: got %0d beats expected 6", cap_d.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++; if (cap_d[i] !== exp_d[i]) begin errors++; $display("FAIL mb1_data[%0d]: got %0h expected %0h", i, cap_d[i], exp_d[i]); end
        checks++; if (cap_l[i] !== 1'b1) begin errors++; $display("FAIL mb1_last[%0d]: got %0b expected 1", i, cap_l[i]); end
        checks++; if (cap_s[i] !== exp_s[i]) begin errors++; $display("FAIL mb1_sel[%0d]: got %0b expected %0b", i, cap_s[i], exp_s[i]); end
      end
      checks++; if (cap_c[5] - cap_c[0] !== 5) begin errors++; $display("FAIL mb1_back_to_back: span got %0d expected 5", cap_c[5] - cap_c[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_forced_release();
    test_backpressure();
    test_single();
    test_max_burst_one();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
